// File: rtl/rtype_pkg.sv
// Shared types and constants for the R-type issue front end.
package rtype_pkg;

    // Operation codes carried on the request interface; 10..15 are undefined.
    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLL  = 4'd2,
        OP_SLT  = 4'd3,
        OP_SLTU = 4'd4,
        OP_XOR  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_OR   = 4'd8,
        OP_AND  = 4'd9
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_BUBBLE = 2'd2
    } state_e;

    // Queued request; op kept as raw bits so undefined codes survive to dequeue.
    typedef struct packed {
        logic [3:0] op;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } req_t;

    localparam int REQ_W = $bits(req_t);

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [1:0] ALUOP_R    = 2'b10;
    localparam logic [1:0] ALUOP_IDLE = 2'b00;

    function automatic logic op_legal(logic [3:0] op);
        return op <= OP_AND;
    endfunction

    // Build the 32-bit R-type word; undefined ops fall back to ADD fields
    // but are never issued.
    function automatic logic [31:0] encode(req_t r);
        logic [6:0] f7;
        logic [2:0] f3;
        f7 = F7_BASE;
        f3 = F3_ADD_SUB;
        case (r.op)
            OP_ADD:  f3 = F3_ADD_SUB;
            OP_SUB:  begin f7 = F7_ALT; f3 = F3_ADD_SUB; end
            OP_SLL:  f3 = F3_SLL;
            OP_SLT:  f3 = F3_SLT;
            OP_SLTU: f3 = F3_SLTU;
            OP_XOR:  f3 = F3_XOR;
            OP_SRL:  f3 = F3_SRL_SRA;
            OP_SRA:  begin f7 = F7_ALT; f3 = F3_SRL_SRA; end
            OP_OR:   f3 = F3_OR;
            OP_AND:  f3 = F3_AND;
            default: ;
        endcase
        return {f7, r.rs2, r.rs1, f3, r.rd, OPC_RTYPE};
    endfunction

endpackage

// File: rtl/rtype_fifo.sv
// Synchronous FIFO, power-of-two depth. A push while full is taken only
// when a pop frees the slot in the same cycle.
module rtype_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 19
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [AW-1:0]               wptr_q, wptr_d;
    logic [AW-1:0]               rptr_q, rptr_d;
    logic [CW-1:0]               cnt_q, cnt_d;
    logic                        do_push, do_pop;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    assign rdata = mem_q[rptr_q];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Next pointer/occupancy and storage write.
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) begin
            mem_d[wptr_q] = wdata;
            wptr_d        = wptr_q + AW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: ;
        endcase
    end

    // Control registers; reset empties the queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset; occupancy decides what is valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/rtype_issue.sv
// Issue front end: queue decoded requests, encode to R-type words and
// present them to the datapath with a fixed bubble gap between issues.
module rtype_issue
    import rtype_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int GAP   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [4:0]  req_rd,
    input  logic [4:0]  req_rs1,
    input  logic [4:0]  req_rs2,
    output logic [31:0] instr,
    output logic [1:0]  ALUOp,
    output logic        reg_write,
    output logic        issue_valid,
    output logic [15:0] issued_cnt,
    output logic        illegal
);

    localparam int CW = $clog2(DEPTH) + 1;
    // Bubble counter counts down from GAP-1 to 0, giving GAP bubble cycles.
    localparam logic [3:0] GAP_LD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    state_e      state_q, state_d;
    logic [3:0]  bub_q, bub_d;
    logic [31:0] instr_q, instr_d;
    logic [1:0]  aluop_q, aluop_d;
    logic        reg_write_q, reg_write_d;
    logic        issue_valid_q, issue_valid_d;
    logic [15:0] issued_cnt_q, issued_cnt_d;
    logic        illegal_q, illegal_d;

    logic             push, pop, full, empty, more;
    logic [CW-1:0]    fifo_cnt;
    logic [REQ_W-1:0] wdata, rdata;
    req_t             head;
    logic             fire, drop;

    assign req_ready = !full;
    assign push      = req_valid && req_ready;
    assign wdata     = {req_op, req_rd, req_rs1, req_rs2};
    assign head      = req_t'(rdata);
    assign pop       = (state_q == ST_ISSUE);

    rtype_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .count (fifo_cnt)
    );

    // Something remains after this cycle's pop (counting a same-cycle push).
    assign more = (fifo_cnt > CW'(1)) || push;

    // Next-state: IDLE waits for work, ISSUE pops one entry, BUBBLE spaces issues.
    always_comb begin
        state_d = state_q;
        bub_d   = bub_q;
        case (state_q)
            ST_IDLE: begin
                if (!empty) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (GAP > 0) begin
                    state_d = ST_BUBBLE;
                    bub_d   = GAP_LD;
                end else if (more) begin
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUBBLE: begin
                if (bub_q == 4'd0) begin
                    state_d = empty ? ST_IDLE : ST_ISSUE;
                end else begin
                    bub_d = bub_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output encoding; an undefined op consumes its issue slot but only pulses illegal.
    always_comb begin
        fire          = (state_q == ST_ISSUE) && op_legal(head.op);
        drop          = (state_q == ST_ISSUE) && !op_legal(head.op);
        instr_d       = fire ? encode(head) : 32'h0000_0000;
        aluop_d       = fire ? ALUOP_R : ALUOP_IDLE;
        reg_write_d   = fire;
        issue_valid_d = fire;
        issued_cnt_d  = issued_cnt_q + 16'(fire);
        illegal_d     = drop;
    end

    // State and registered outputs; reset drops any bubble in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            bub_q         <= 4'd0;
            instr_q       <= 32'h0000_0000;
            aluop_q       <= ALUOP_IDLE;
            reg_write_q   <= 1'b0;
            issue_valid_q <= 1'b0;
            issued_cnt_q  <= 16'd0;
            illegal_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            bub_q         <= bub_d;
            instr_q       <= instr_d;
            aluop_q       <= aluop_d;
            reg_write_q   <= reg_write_d;
            issue_valid_q <= issue_valid_d;
            issued_cnt_q  <= issued_cnt_d;
            illegal_q     <= illegal_d;
        end
    end

    assign instr       = instr_q;
    assign ALUOp       = aluop_q;
    assign reg_write   = reg_write_q;
    assign issue_valid = issue_valid_q;
    assign issued_cnt  = issued_cnt_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_rtype_issue.sv
// Scoreboard bench: dut runs GAP=2, dut0 runs GAP=0; shared clock and reset.
module tb_rtype_issue;

    localparam int G = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        v, rdy, rw, iv, ill;
    logic [3:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] instr;
    logic [1:0]  aluop;
    logic [15:0] icnt;

    logic        v0, rdy0, rw0, iv0, ill0;
    logic [3:0]  op0;
    logic [4:0]  rd0, rs10, rs20;
    logic [31:0] instr0;
    logic [1:0]  aluop0;
    logic [15:0] icnt0;

    rtype_issue #(.DEPTH(4), .GAP(G)) dut (
        .clk(clk), .reset(rst), .req_valid(v), .req_ready(rdy), .req_op(op),
        .req_rd(rd), .req_rs1(rs1), .req_rs2(rs2), .instr(instr), .ALUOp(aluop),
        .reg_write(rw), .issue_valid(iv), .issued_cnt(icnt), .illegal(ill)
    );

    rtype_issue #(.DEPTH(4), .GAP(0)) dut0 (
        .clk(clk), .reset(rst), .req_valid(v0), .req_ready(rdy0), .req_op(op0),
        .req_rd(rd0), .req_rs1(rs10), .req_rs2(rs20), .instr(instr0), .ALUOp(aluop0),
        .reg_write(rw0), .issue_valid(iv0), .issued_cnt(icnt0), .illegal(ill0)
    );

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] q[$], q0[$];
    logic [31:0] iss_log[$];
    int          iss_cyc[$];
    int          acc_cyc;
    int          ill_seen = 0;
    logic [15:0] exp_cnt = 16'd0;
    int          run0 = 0, max_run0 = 0, iss0 = 0;
    bit          full_seen = 1'b0;
    bit          mon_en = 1'b0;

    task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference encoding written straight from the op table.
    function automatic logic [31:0] model(logic [3:0] o, logic [4:0] d, logic [4:0] s1, logic [4:0] s2);
        logic [6:0] f7;
        logic [2:0] f3;
        f7 = (o == 4'd1 || o == 4'd7) ? 7'b0100000 : 7'b0000000;
        case (o)
            4'd0, 4'd1: f3 = 3'd0;
            4'd2:       f3 = 3'd1;
            4'd3:       f3 = 3'd2;
            4'd4:       f3 = 3'd3;
            4'd5:       f3 = 3'd4;
            4'd6, 4'd7: f3 = 3'd5;
            4'd8:       f3 = 3'd6;
            default:    f3 = 3'd7;
        endcase
        return {f7, s2, s1, f3, d, 7'b0110011};
    endfunction

    // Monitor for the GAP=2 instance.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (!rdy) full_seen = 1'b1;
            if (ill) ill_seen++;
            if (iv) begin
                logic [31:0] e;
                e = (q.size() > 0) ? q.pop_front() : 32'hxxxx_xxxx;
                chk("instr", instr, e);
                chk("aluop_issue", {30'd0, aluop}, 32'd2);
                chk("reg_write_issue", {31'd0, rw}, 32'd1);
                exp_cnt++;
                chk("issued_cnt", {16'd0, icnt}, {16'd0, exp_cnt});
                iss_log.push_back(instr);
                iss_cyc.push_back(cyc);
            end else begin
                chk("instr_idle", instr, 32'd0);
                chk("aluop_idle", {30'd0, aluop}, 32'd0);
                chk("reg_write_idle", {31'd0, rw}, 32'd0);
            end
        end
    end

    // Monitor for the GAP=0 instance.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (iv0) begin
                logic [31:0] e;
                e = (q0.size() > 0) ? q0.pop_front() : 32'hxxxx_xxxx;
                chk("instr_gap0", instr0, e);
                run0++;
                iss0++;
                if (run0 > max_run0) max_run0 = run0;
            end else begin
                run0 = 0;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; v = 1'b0; v0 = 1'b0;
        q.delete(); q0.delete(); iss_log.delete(); iss_cyc.delete();
        exp_cnt = 16'd0; run0 = 0; max_run0 = 0; iss0 = 0; full_seen = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Hold a request until accepted; called and returns at a falling edge.
    task automatic send(bit sel, logic [3:0] o, logic [4:0] d, logic [4:0] s1, logic [4:0] s2);
        int t = 0;
        if (sel) begin v0 = 1'b1; op0 = o; rd0 = d; rs10 = s1; rs20 = s2; end
        else     begin v  = 1'b1; op  = o; rd  = d; rs1  = s1; rs2  = s2; end
        while (!(sel ? rdy0 : rdy) && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("accept_in_time", {31'd0, t < 100}, 32'd1);
        if (t < 100 && o <= 4'd9) begin
            if (sel) q0.push_back(model(o, d, s1, s2));
            else     q.push_back(model(o, d, s1, s2));
        end
        @(negedge clk);
        acc_cyc = cyc;
    endtask

    task automatic drain(bit sel);
        int t = 0;
        while ((sel ? q0.size() : q.size()) != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("drain_in_time", {31'd0, t < 300}, 32'd1);
        repeat (G + 4) @(negedge clk);
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_ready"}, {31'd0, rdy}, 32'd1);
        chk({tag, "_valid"}, {31'd0, iv}, 32'd0);
        chk({tag, "_instr"}, instr, 32'd0);
        chk({tag, "_aluop"}, {30'd0, aluop}, 32'd0);
        chk({tag, "_rw"}, {31'd0, rw}, 32'd0);
        chk({tag, "_cnt"}, {16'd0, icnt}, 32'd0);
        chk({tag, "_illegal"}, {31'd0, ill}, 32'd0);
    endtask

    initial begin
        int ill_base;
        rst = 1'b1; v = 1'b0; v0 = 1'b0;
        op = '0; rd = '0; rs1 = '0; rs2 = '0;
        op0 = '0; rd0 = '0; rs10 = '0; rs20 = '0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        mon_en = 1'b1;

        // Single ADD: encoding, latency and count.
        send(1'b0, 4'd0, 5'd3, 5'd2, 5'd1);
        v = 1'b0;
        drain(1'b0);
        chk("add_instr", iss_log[0], 32'h001101B3);
        chk("add_latency", iss_cyc[0] - acc_cyc, 32'd2);
        chk("add_cnt", {16'd0, icnt}, 32'd1);
        chk("add_issues", iss_log.size(), 32'd1);

        // SUB then SRA: words and spacing of GAP+1.
        do_reset();
        send(1'b0, 4'd1, 5'd5, 5'd6, 5'd7);
        send(1'b0, 4'd7, 5'd1, 5'd1, 5'd2);
        v = 1'b0;
        drain(1'b0);
        chk("sub_instr", iss_log[0], 32'h407302B3);
        chk("sra_instr", iss_log[1], 32'h4020D0B3);
        chk("issue_spacing", iss_cyc[1] - iss_cyc[0], 32'd3);

        // Burst of 6: back-pressure appears, all issue in order.
        do_reset();
        for (int i = 0; i < 6; i++) send(1'b0, 4'(i + 2), 5'(i + 1), 5'(i + 9), 5'(i + 20));
        v = 1'b0;
        drain(1'b0);
        chk("burst_backpressure", {31'd0, full_seen}, 32'd1);
        chk("burst_issues", iss_log.size(), 32'd6);
        chk("burst_cnt", {16'd0, icnt}, 32'd6);

        // Undefined op between two legal ones.
        do_reset();
        ill_base = ill_seen;
        send(1'b0, 4'd0, 5'd4, 5'd5, 5'd6);
        send(1'b0, 4'd12, 5'd7, 5'd8, 5'd9);
        send(1'b0, 4'd9, 5'd10, 5'd11, 5'd12);
        v = 1'b0;
        drain(1'b0);
        chk("illegal_pulses", ill_seen - ill_base, 32'd1);
        chk("illegal_cnt", {16'd0, icnt}, 32'd2);
        chk("illegal_issues", iss_log.size(), 32'd2);

        // Reset with 3 entries queued during a bubble.
        do_reset();
        for (int i = 0; i < 4; i++) send(1'b0, 4'(i), 5'(i + 1), 5'(i + 2), 5'(i + 3));
        v = 1'b0;
        rst = 1'b1;
        q.delete(); iss_log.delete(); iss_cyc.delete(); exp_cnt = 16'd0;
        @(negedge clk);
        chk_reset_vals("midreset");
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("midreset_no_issue", iss_log.size(), 32'd0);
        chk("midreset_cnt", {16'd0, icnt}, 32'd0);

        // GAP=0: four queued requests issue back to back.
        do_reset();
        for (int i = 0; i < 4; i++) send(1'b1, 4'(9 - i), 5'(i + 3), 5'(i + 17), 5'(31 - i));
        v0 = 1'b0;
        drain(1'b1);
        chk("gap0_run", max_run0, 32'd4);
        chk("gap0_issues", iss0, 32'd4);
        chk("gap0_cnt", {16'd0, icnt0}, 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
